// File: rtl/operand_fetch_pkg.sv
// Shared decode helpers for the RV32I operand-fetch stage.
// Opcodes and register-field positions.
package operand_fetch_pkg;

  typedef enum logic [6:0] {
    OP_R      = 7'b0110011,
    OP_IMM    = 7'b0010011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111
  } opcode_e;

  localparam int RD_LSB  = 7;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;

  function automatic logic uses_rs1(input logic [31:0] ins);
    return ins[6:0] inside {OP_R, OP_IMM, OP_LOAD,
                            OP_STORE, OP_BRANCH, OP_JALR};
  endfunction

  function automatic logic uses_rs2(input logic [31:0] ins);
    return ins[6:0] inside {OP_R, OP_STORE, OP_BRANCH};
  endfunction

  // x0 destinations never occupy the scoreboard
  function automatic logic writes_rd(input logic [31:0] ins);
    return (ins[6:0] inside {OP_R, OP_IMM, OP_LOAD, OP_JAL,
                             OP_JALR, OP_LUI, OP_AUIPC})
           && (ins[RD_LSB +: 5] != 5'd0);
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register.
// A same-cycle set wins over writeback clear or flush kill.
module reg_scoreboard #(
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_en,
  input  logic [AW-1:0]    set_a,
  input  logic             clr_en,
  input  logic [AW-1:0]    clr_a,
  input  logic             kill_en,
  input  logic [AW-1:0]    kill_a,
  output logic [NREGS-1:0] pending
);

  logic [NREGS-1:0] r_pend;
  logic [NREGS-1:0] w_one;
  logic [NREGS-1:0] w_set;
  logic [NREGS-1:0] w_clr;
  logic [NREGS-1:0] w_kill;

  assign w_one  = NREGS'(1);
  assign w_set  = set_en  ? (w_one << set_a)  : '0;
  assign w_clr  = clr_en  ? (w_one << clr_a)  : '0;
  assign w_kill = kill_en ? (w_one << kill_a) : '0;

  always_ff @(posedge clk) begin
    if (rst)
      r_pend <= '0;
    else
      r_pend <= ((r_pend & ~w_clr & ~w_kill) | w_set) & ~w_one;
  end

  assign pending = r_pend;

endmodule

// File: rtl/operand_fetch.sv
// Decode/operand-fetch stage: regfile read, writeback forwarding,
// scoreboard hazard stall and the output pipeline register.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREGS = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [WIDTH-1:0] in_pc,
  output logic [AW-1:0]    rf_a1,
  output logic [AW-1:0]    rf_a2,
  input  logic [WIDTH-1:0] rf_rd1,
  input  logic [WIDTH-1:0] rf_rd2,
  input  logic             wb_we,
  input  logic [AW-1:0]    wb_a3,
  input  logic [WIDTH-1:0] wb_wd,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [WIDTH-1:0] out_pc,
  output logic [WIDTH-1:0] out_rs1_val,
  output logic [WIDTH-1:0] out_rs2_val
);

  logic             r_valid;
  logic [31:0]      r_instr;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_rs1;
  logic [WIDTH-1:0] r_rs2;

  logic [AW-1:0]    w_rs1;
  logic [AW-1:0]    w_rs2;
  logic [AW-1:0]    w_rd;
  logic [AW-1:0]    w_out_rd;
  logic             w_use1;
  logic             w_use2;
  logic             w_wr;
  logic             w_out_wr;
  logic [NREGS-1:0] w_pend;
  logic [NREGS-1:0] w_clr;
  logic [NREGS-1:0] w_busy;
  logic             w_hazard;
  logic             w_acc;
  logic [WIDTH-1:0] w_op1;
  logic [WIDTH-1:0] w_op2;

  assign w_rs1    = in_instr[RS1_LSB +: AW];
  assign w_rs2    = in_instr[RS2_LSB +: AW];
  assign w_rd     = in_instr[RD_LSB +: AW];
  assign w_out_rd = r_instr[RD_LSB +: AW];
  assign w_use1   = uses_rs1(in_instr);
  assign w_use2   = uses_rs2(in_instr);
  assign w_wr     = writes_rd(in_instr);
  assign w_out_wr = writes_rd(r_instr);

  assign rf_a1 = w_rs1;
  assign rf_a2 = w_rs2;

  // A register retiring this cycle is no longer busy
  assign w_clr  = (wb_we && wb_a3 != '0) ? (NREGS'(1) << wb_a3) : '0;
  assign w_busy = w_pend & ~w_clr;

  assign w_hazard = (w_use1 && w_busy[w_rs1])
                 || (w_use2 && w_busy[w_rs2])
                 || (w_wr && w_busy[w_rd]);

  assign in_ready = !rst && !flush && !w_hazard
                 && (!r_valid || out_ready);
  assign w_acc    = in_valid && in_ready;

  assign w_op1 = (w_rs1 == '0) ? '0
               : w_clr[w_rs1]  ? wb_wd : rf_rd1;
  assign w_op2 = (w_rs2 == '0) ? '0
               : w_clr[w_rs2]  ? wb_wd : rf_rd2;

  reg_scoreboard #(
    .NREGS(NREGS),
    .AW   (AW)
  ) u_sb (
    .clk    (clk),
    .rst    (rst),
    .set_en (w_acc && w_wr),
    .set_a  (w_rd),
    .clr_en (wb_we),
    .clr_a  (wb_a3),
    .kill_en(flush && r_valid && w_out_wr),
    .kill_a (w_out_rd),
    .pending(w_pend)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
      r_rs1   <= '0;
      r_rs2   <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_acc) begin
      r_valid <= 1'b1;
      r_instr <= in_instr;
      r_pc    <= in_pc;
      r_rs1   <= w_op1;
      r_rs2   <= w_op2;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid   = r_valid;
  assign out_instr   = r_instr;
  assign out_pc      = r_pc;
  assign out_rs1_val = r_rs1;
  assign out_rs2_val = r_rs2;

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed scenarios
// followed by random traffic against a behavioural model.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [4:0]  rf_a1;
  logic [4:0]  rf_a2;
  logic [31:0] rf_rd1;
  logic [31:0] rf_rd2;
  logic        wb_we;
  logic [4:0]  wb_a3;
  logic [31:0] wb_wd;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_rs1_val;
  logic [31:0] out_rs2_val;

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  bit          m_valid;
  logic [31:0] m_instr, m_pc, m_r1, m_r2;
  bit   [31:0] m_pend;

  operand_fetch #(.WIDTH(32), .NREGS(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_pc      (in_pc),
    .rf_a1      (rf_a1),
    .rf_a2      (rf_a2),
    .rf_rd1     (rf_rd1),
    .rf_rd2     (rf_rd2),
    .wb_we      (wb_we),
    .wb_a3      (wb_a3),
    .wb_wd      (wb_wd),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_pc     (out_pc),
    .out_rs1_val(out_rs1_val),
    .out_rs2_val(out_rs2_val)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit reads1(input logic [31:0] i);
    case (i[6:0])
      7'b0110011, 7'b0010011, 7'b0000011,
      7'b0100011, 7'b1100011, 7'b1100111: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit reads2(input logic [31:0] i);
    case (i[6:0])
      7'b0110011, 7'b0100011, 7'b1100011: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit writes(input logic [31:0] i);
    case (i[6:0])
      7'b0110011, 7'b0010011, 7'b0000011, 7'b1101111,
      7'b1100111, 7'b0110111, 7'b0010111: return i[11:7] != 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit retiring(input logic [4:0] r);
    return wb_we && wb_a3 == r && r != 0;
  endfunction

  function automatic bit busy(input logic [4:0] r);
    return m_pend[r] && !retiring(r);
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] r,
                                          input logic [31:0] rf);
    if (r == 0) return 0;
    if (retiring(r)) return wb_wd;
    return rf;
  endfunction

  function automatic logic [31:0] r_type(input int rd, rs1, rs2);
    return {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), 7'b0110011};
  endfunction

  function automatic logic [31:0] addi(input int rd, rs1, imm);
    return {12'(imm), 5'(rs1), 3'd0, 5'(rd), 7'b0010011};
  endfunction

  // one clock: check comb outputs, advance model, check registers
  task automatic cycle();
    logic [4:0]  s1, s2, d;
    bit          hz, er, acc;
    bit   [31:0] np;
    bit          nv;
    logic [31:0] ni, npc, n1, n2;
    #1;
    s1 = in_instr[19:15];
    s2 = in_instr[24:20];
    d  = in_instr[11:7];
    hz = (reads1(in_instr) && busy(s1))
      || (reads2(in_instr) && busy(s2))
      || (writes(in_instr) && busy(d));
    er = !rst && !flush && !hz && (!m_valid || out_ready);
    check("in_ready", {31'd0, in_ready}, {31'd0, er});
    check("rf_a1", {27'd0, rf_a1}, {27'd0, s1});
    check("rf_a2", {27'd0, rf_a2}, {27'd0, s2});
    acc = in_valid && er;
    np = m_pend;
    nv = m_valid;
    ni = m_instr; npc = m_pc; n1 = m_r1; n2 = m_r2;
    if (wb_we && wb_a3 != 0) np[wb_a3] = 1'b0;
    if (flush && m_valid && writes(m_instr)) np[m_instr[11:7]] = 1'b0;
    if (acc && writes(in_instr)) np[d] = 1'b1;
    if (flush) nv = 1'b0;
    else if (acc) begin
      nv = 1'b1; ni = in_instr; npc = in_pc;
      n1 = operand(s1, rf_rd1);
      n2 = operand(s2, rf_rd2);
    end else if (out_ready) nv = 1'b0;
    if (rst) begin
      np = 0; nv = 0; ni = 0; npc = 0; n1 = 0; n2 = 0;
    end
    @(posedge clk);
    #1;
    m_pend = np; m_valid = nv; m_instr = ni; m_pc = npc;
    m_r1 = n1; m_r2 = n2;
    check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    check("out_instr", out_instr, m_instr);
    check("out_pc", out_pc, m_pc);
    check("out_rs1", out_rs1_val, m_r1);
    check("out_rs2", out_rs2_val, m_r2);
    check("pending", dut.u_sb.pending, m_pend);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [10];
    logic [31:0] i;
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
            7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
            7'b0010111, 7'b1110011};
    i = $urandom;
    i[6:0]   = ops[$urandom_range(0, 9)];
    i[11:7]  = 5'($urandom_range(0, 7));
    i[19:15] = 5'($urandom_range(0, 7));
    i[24:20] = 5'($urandom_range(0, 7));
    return i;
  endfunction

  initial begin
    rst = 1'b1; in_valid = 0; in_instr = 0; in_pc = 0;
    rf_rd1 = 0; rf_rd2 = 0; wb_we = 0; wb_a3 = 0; wb_wd = 0;
    flush = 0; out_ready = 1;
    m_valid = 0; m_instr = 0; m_pc = 0; m_r1 = 0; m_r2 = 0; m_pend = 0;
    @(posedge clk);
    #1;
    cycle();
    rst = 1'b0;

    // 1: ADD x3,x1,x2
    in_valid = 1; in_instr = r_type(3, 1, 2); in_pc = 32'h100;
    rf_rd1 = 5; rf_rd2 = 7;
    cycle();
    check("t1_rs1", out_rs1_val, 32'd5);
    check("t1_rs2", out_rs2_val, 32'd7);
    check("t1_pend3", {31'd0, dut.u_sb.pending[3]}, 32'd1);

    // 2: RAW stall then forwarded release
    in_instr = addi(4, 3, 1); in_pc = 32'h104; rf_rd1 = 32'hdead;
    cycle();
    check("t2_stall", {31'd0, out_valid}, 32'd0);
    wb_we = 1; wb_a3 = 3; wb_wd = 32'h1234;
    cycle();
    wb_we = 0;
    check("t2_fwd", out_rs1_val, 32'h1234);
    check("t2_pend", dut.u_sb.pending & 32'h18, 32'h10);

    // 3: back-pressure holds everything
    out_ready = 0; in_instr = r_type(5, 1, 2); in_pc = 32'h108;
    rf_rd1 = 11; rf_rd2 = 22;
    repeat (3) cycle();
    check("t3_hold", out_instr, addi(4, 3, 1));
    out_ready = 1;
    cycle();
    check("t3_next", out_instr, r_type(5, 1, 2));

    in_valid = 0; wb_we = 1; wb_a3 = 4; cycle();
    wb_a3 = 5; cycle();
    wb_we = 0;

    // 4: x0 destination and x0 source
    in_valid = 1; in_instr = {20'habcde, 5'd0, 7'b0110111};
    in_pc = 32'h10c; rf_rd1 = 32'h55; rf_rd2 = 32'h66;
    cycle();
    in_instr = {7'd0, 5'd5, 5'd0, 3'b010, 5'd0, 7'b0100011};
    in_pc = 32'h110; rf_rd1 = 0; rf_rd2 = 9;
    cycle();
    check("t4_pend", dut.u_sb.pending, 32'd0);
    check("t4_rs1", out_rs1_val, 32'd0);
    check("t4_rs2", out_rs2_val, 32'd9);

    // 5: flush of a held writer
    in_instr = r_type(6, 1, 2); in_pc = 32'h114; rf_rd1 = 1; rf_rd2 = 2;
    cycle();
    out_ready = 0; flush = 1; in_instr = r_type(8, 1, 2);
    cycle();
    flush = 0; out_ready = 1;
    check("t5_valid", {31'd0, out_valid}, 32'd0);
    check("t5_pend", dut.u_sb.pending & 32'h140, 32'd0);

    // 6: WAW release with set-beats-clear, then reset mid-stall
    in_instr = r_type(7, 1, 2); in_pc = 32'h118;
    cycle();
    wb_we = 1; wb_a3 = 7; wb_wd = 32'h77; in_pc = 32'h11c;
    cycle();
    wb_we = 0;
    check("t6_set_wins", {31'd0, dut.u_sb.pending[7]}, 32'd1);
    in_instr = addi(9, 7, 1); in_pc = 32'h120;
    cycle();
    rst = 1;
    cycle();
    rst = 0;
    check("t6_rst_valid", {31'd0, out_valid}, 32'd0);
    check("t6_rst_pend", dut.u_sb.pending, 32'd0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 99) == 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      in_instr  = rand_instr();
      in_pc     = $urandom;
      rf_rd1    = (in_instr[19:15] == 0) ? 0 : $urandom;
      rf_rd2    = (in_instr[24:20] == 0) ? 0 : $urandom;
      wb_we     = ($urandom_range(0, 9) < 4);
      wb_a3     = 5'($urandom_range(0, 7));
      wb_wd     = $urandom;
      flush     = ($urandom_range(0, 9) == 0);
      out_ready = ($urandom_range(0, 9) < 7);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
